// File: rtl/alu_mul_seq_pkg.sv
// -----------------------------------------------------------------------------
// alu_mul_seq_pkg
// Shared definitions for the shift-and-add multiply sequencer: the default
// operand width, the controller state encoding and the ALU mode constant.
// -----------------------------------------------------------------------------
package alu_mul_seq_pkg;

    // Default operand width; the product is twice this.
    localparam int DEFAULT_WIDTH = 8;

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // The shared ALU adds when its mode input is 0.
    localparam logic ALU_M_ADD = 1'b0;

endpackage

// File: rtl/alu_mul_seq_if.sv
// -----------------------------------------------------------------------------
// alu_mul_seq_if
// Bundles the request/response handshake and the ALU operand/result bus of
// the multiply sequencer.
//
// Handshake: the issuer raises start with a/b valid; the request is taken
// on the clock edge where start=1 and the sequencer is idle or done (busy=0).
// While busy=1 start is ignored. done is a single-cycle pulse; product is
// valid from that cycle and holds until the next completion.
//
//   start    issuer -> seq   request
//   a, b     issuer -> seq   multiplicand / multiplier
//   busy     seq -> issuer   operation in progress
//   done     seq -> issuer   one-cycle completion pulse
//   product  seq -> issuer   registered 2*WIDTH result
//   alu_a    seq -> ALU      operand a (accumulator high half)
//   alu_b    seq -> ALU      operand b (latched multiplicand)
//   alu_m    seq -> ALU      mode (always add)
//   alu_out  ALU -> seq      combinational sum of alu_a + alu_b
// -----------------------------------------------------------------------------
import alu_mul_seq_pkg::*;

interface alu_mul_seq_if #(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic                   start;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     product;
    logic [WIDTH-1:0]       alu_a;
    logic [WIDTH-1:0]       alu_b;
    logic                   alu_m;
    logic [WIDTH-1:0]       alu_out;

    // Issuer side (together with the ALU, which returns alu_out).
    modport master (
        output start, a, b, alu_out,
        input  busy, done, product, alu_a, alu_b, alu_m
    );

    // Sequencer side.
    modport slave (
        input  start, a, b, alu_out,
        output busy, done, product, alu_a, alu_b, alu_m
    );
endinterface

// File: rtl/alu_mul_seq.sv
// -----------------------------------------------------------------------------
// alu_mul_seq
// Drives an external 8-bit adder ALU to form an unsigned WIDTH x WIDTH
// product by shift-and-add: one ALU add per iteration, WIDTH iterations.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high reset
//   bus    alu_mul_seq_if.slave (start/a/b/busy/done/product and the
//          alu_a/alu_b/alu_m/alu_out ALU bus)
//   state  current controller state, for observation
// -----------------------------------------------------------------------------
import alu_mul_seq_pkg::*;

module alu_mul_seq #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic          clk,
    input  logic          reset,
    alu_mul_seq_if.slave  bus,
    output state_t        state
);

    localparam int CW = $clog2(WIDTH);

    state_t             state_q;
    state_t             state_d;

    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] product_q;

    logic               carry;
    logic               accept;
    logic               last;
    logic [2*WIDTH:0]   pre_shift;
    logic [2*WIDTH-1:0] shifted;

    // ------------------------------------------------------------------
    // Datapath step
    // ------------------------------------------------------------------
    always_comb begin
        // The ALU has no carry-out: an unsigned add wrapped exactly when
        // the sum is smaller than one of its operands.
        carry = (bus.alu_out < acc);

        // Multiplier LSB selects add-then-shift or plain shift of the
        // {carry, acc, mplier} window.
        if (mplier[0]) begin
            pre_shift = {carry, bus.alu_out, mplier};
        end else begin
            pre_shift = {1'b0, acc, mplier};
        end
        shifted = pre_shift[2*WIDTH:1];

        last   = (count == CW'(WIDTH - 1));
        accept = bus.start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.start) state_d = ST_RUN;
            ST_RUN:  if (last)      state_d = ST_DONE;
            ST_DONE: state_d = bus.start ? ST_RUN : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            count     <= '0;
            product_q <= '0;
        end else if (accept) begin
            // product is deliberately left alone: it holds the previous
            // result until this new operation completes.
            acc    <= '0;
            mcand  <= bus.a;
            mplier <= bus.b;
            count  <= '0;
        end else if (state_q == ST_RUN) begin
            acc    <= shifted[2*WIDTH-1:WIDTH];
            mplier <= shifted[WIDTH-1:0];
            count  <= count + 1'b1;
            if (last) begin
                product_q <= shifted;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs: all decoded from registers
    // ------------------------------------------------------------------
    assign bus.alu_a   = acc;
    assign bus.alu_b   = mcand;
    assign bus.alu_m   = ALU_M_ADD;
    assign bus.busy    = (state_q == ST_RUN);
    assign bus.done    = (state_q == ST_DONE);
    assign bus.product = product_q;
    assign state       = state_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_mul_seq
// Bench for alu_mul_seq with a behavioural 8-bit adder standing in for the
// shared ALU. Expected products come from plain a*b arithmetic.
// -----------------------------------------------------------------------------
import alu_mul_seq_pkg::*;

module tb_alu_mul_seq;

    localparam int W = 8;

    logic   clk;
    logic   reset;
    state_t state;

    alu_mul_seq_if #(.WIDTH(W)) bus ();

    alu_mul_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .state (state)
    );

    // Behavioural ALU: 8-bit add when mode is 0, wraps without carry-out.
    assign bus.alu_out = bus.alu_m ? (bus.alu_a - bus.alu_b) : (bus.alu_a + bus.alu_b);

    // ------------------------------------------------------------------
    // Clock
    // ------------------------------------------------------------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    int checks = 0;
    int errors = 0;
    logic [2*W-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Reference: the product is just the unsigned arithmetic product.
    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
        return (2*W)'(x) * (2*W)'(y);
    endfunction

    // ------------------------------------------------------------------
    // Driver: issue one multiply from a negedge and follow it to done.
    // inject_k > 0 pulses a stray start (a=3,b=3) during RUN cycle inject_k
    // and then scrambles a/b. Returns at the negedge where done is high.
    // ------------------------------------------------------------------
    task automatic run_check(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                             input int inject_k, input logic [2*W-1:0] prev_product);
        int done_seen;
        logic [2*W-1:0] exp;
        done_seen = 0;
        exp_q.push_back(ref_mul(x, y));
        bus.start = 1'b1;
        bus.a     = x;
        bus.b     = y;
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            if (bus.done) done_seen++;
            if (k == 1) begin
                check({name, " alu_b latched"}, 32'(bus.alu_b), 32'(x));
                check({name, " alu_m"}, 32'(bus.alu_m), 32'(ALU_M_ADD));
            end
            if (k < 9) begin
                check({name, " busy"}, 32'(bus.busy), 32'd1);
                if (k == 4) check({name, " product held"}, 32'(bus.product), 32'(prev_product));
                if (k == inject_k) begin
                    bus.start = 1'b1;
                    bus.a     = 8'd3;
                    bus.b     = 8'd3;
                end else begin
                    bus.start = 1'b0;
                    if (inject_k != 0 && k > inject_k) begin
                        bus.a = W'($urandom_range(0, 255));
                        bus.b = W'($urandom_range(0, 255));
                    end
                end
                @(negedge clk);
            end
        end
        bus.start = 1'b0;
        exp = exp_q.pop_front();
        check({name, " done"}, 32'(bus.done), 32'd1);
        check({name, " busy at done"}, 32'(bus.busy), 32'd0);
        check({name, " done pulses"}, 32'(done_seen), 32'd1);
        check({name, " product"}, 32'(bus.product), 32'(exp));
    endtask

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] exp;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        vecs[0] = '{a: 8'd13,  b: 8'd11,  exp: 16'd143};
        vecs[1] = '{a: 8'd255, b: 8'd255, exp: 16'd65025};
        vecs[2] = '{a: 8'd0,   b: 8'd200, exp: 16'd0};
        vecs[3] = '{a: 8'd200, b: 8'd0,   exp: 16'd0};
        vecs[4] = '{a: 8'd1,   b: 8'd1,   exp: 16'd1};

        // Reset held 2 cycles
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset busy",    32'(bus.busy),    32'd0);
        check("reset done",    32'(bus.done),    32'd0);
        check("reset product", 32'(bus.product), 32'd0);
        check("reset state",   32'(state),       32'(ST_IDLE));

        // Table-driven vectors
        for (int i = 0; i < 5; i++) begin
            check($sformatf("table%0d model", i), 32'(ref_mul(vecs[i].a, vecs[i].b)), 32'(vecs[i].exp));
            run_check($sformatf("table%0d", i), vecs[i].a, vecs[i].b, 0, bus.product);
            @(negedge clk);
            check($sformatf("table%0d idle after", i), 32'(bus.done), 32'd0);
        end

        // Stray start during a 7x9 run, then back-to-back 2x5 from DONE
        run_check("mid_start 7x9", 8'd7, 8'd9, 3, bus.product);
        run_check("b2b 2x5", 8'd2, 8'd5, 0, bus.product);
        @(negedge clk);
        check("b2b done one cycle", 32'(bus.done), 32'd0);
        check("b2b idle", 32'(state), 32'(ST_IDLE));

        // Reset abort at RUN cycle 4 of 100x100
        bus.start = 1'b1;
        bus.a     = 8'd100;
        bus.b     = 8'd100;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check("abort busy before", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort state",   32'(state),       32'(ST_IDLE));
        check("abort product", 32'(bus.product), 32'd0);
        check("abort done",    32'(bus.done),    32'd0);
        for (int k = 0; k < 10; k++) begin
            if (bus.done || bus.busy) check("abort stays idle", {30'd0, bus.busy, bus.done}, 32'd0);
            @(negedge clk);
        end
        check("abort still idle", 32'(state), 32'(ST_IDLE));
        run_check("after abort 100x100", 8'd100, 8'd100, 0, 16'd0);
        @(negedge clk);

        // Randomized operands against the arithmetic model
        for (int i = 0; i < 20; i++) begin
            ra = W'($urandom_range(0, 255));
            rb = W'($urandom_range(0, 255));
            run_check($sformatf("rand%0d %0dx%0d", i, ra, rb), ra, rb, 0, bus.product);
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
